// File: rtl/router_pkt_injector_if.sv
// rtl/router_pkt_injector_if.sv - descriptor request and flit output bundle for router_pkt_injector
interface router_pkt_injector_if #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 4
);
    logic              req_valid;
    logic              req_ready;
    logic              req_port;
    logic [LEN_W-1:0]  req_len;
    logic [DATA_W-1:0] req_seed;
    logic              fifo_full;
    logic              flit_valid;
    logic              flit_port;
    logic              flit_head;
    logic              flit_tail;
    logic [DATA_W-1:0] flit_data;

    // Injector side: consumes descriptors, produces flits.
    modport master (
        input  req_valid, req_port, req_len, req_seed, fifo_full,
        output req_ready, flit_valid, flit_port, flit_head, flit_tail, flit_data
    );

    // Environment side: supplies descriptors and backpressure, receives flits.
    modport slave (
        output req_valid, req_port, req_len, req_seed, fifo_full,
        input  req_ready, flit_valid, flit_port, flit_head, flit_tail, flit_data
    );
endinterface

// File: rtl/router_pkt_injector.sv
// rtl/router_pkt_injector.sv - segments packet descriptors into head/body/tail flits for one router input
module router_pkt_injector #(
    parameter int DATA_W  = 16,
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 inj_en,
    router_pkt_injector_if.master bus,
    output logic                 err_len,
    output logic [CNT_W-1:0]     pkt_cnt,
    output logic [CNT_W-1:0]     stall_cnt
);
    typedef enum logic {IDLE, SEND} state_t;

    state_t             state, state_nxt;
    logic               port_q;
    logic [LEN_W-1:0]   len_q;
    logic [DATA_W-1:0]  seed_q;
    logic [LEN_W-1:0]   idx_q;

    logic               in_send;
    logic               is_tail;
    logic               valid_int;
    logic               ready_int;
    logic               accept;
    logic               len_ok;
    logic               load;
    logic               idx_inc;
    logic               pkt_done;
    logic               err_nxt;

    // Datapath decode shared by the FSM and the output drivers.
    always_comb begin
        in_send   = (state == SEND);
        is_tail   = in_send && (idx_q == len_q - LEN_W'(1));
        valid_int = in_send && !bus.fifo_full;
        // In SEND a new descriptor can only land on the cycle the tail leaves.
        ready_int = in_send ? (inj_en && !bus.fifo_full && is_tail) : inj_en;
        accept    = bus.req_valid && ready_int;
        len_ok    = (bus.req_len != '0) && (bus.req_len <= LEN_W'(MAX_LEN));
        load      = accept && len_ok;
        err_nxt   = accept && !len_ok;
        idx_inc   = valid_int && !is_tail;
        pkt_done  = valid_int && is_tail;
    end

    // Next-state logic: enter/stay in SEND only on a legal descriptor.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (load) state_nxt = SEND;
            SEND: if (pkt_done) state_nxt = load ? SEND : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state <= IDLE;
        else        state <= state_nxt;
    end

    // Descriptor latch and flit index; a load restarts the index at the head.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            port_q <= 1'b0;
            len_q  <= '0;
            seed_q <= '0;
            idx_q  <= '0;
        end else if (load) begin
            port_q <= bus.req_port;
            len_q  <= bus.req_len;
            seed_q <= bus.req_seed;
            idx_q  <= '0;
        end else if (idx_inc) begin
            idx_q  <= idx_q + LEN_W'(1);
        end
    end

    // Error pulse and statistics: packet count wraps, stall count saturates.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            err_len   <= 1'b0;
            pkt_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            err_len <= err_nxt;
            if (pkt_done) pkt_cnt <= pkt_cnt + CNT_W'(1);
            if (in_send && bus.fifo_full && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign bus.req_ready  = ready_int;
    assign bus.flit_valid = valid_int;
    assign bus.flit_port  = in_send && port_q;
    assign bus.flit_head  = in_send && (idx_q == '0);
    assign bus.flit_tail  = is_tail;
    assign bus.flit_data  = in_send ? (seed_q + DATA_W'(idx_q)) : '0;
endmodule

// File: tb/tb_router_pkt_injector.sv
// tb/tb_router_pkt_injector.sv - directed self-checking bench for router_pkt_injector
module tb_router_pkt_injector;
    logic        clk;
    logic        rst_b;
    logic        inj_en;
    logic        err_len;
    logic [15:0] pkt_cnt;
    logic [15:0] stall_cnt;
    int          n_tests;
    int          n_fail;

    router_pkt_injector_if #(.DATA_W(16), .LEN_W(4)) bus ();

    router_pkt_injector #(.DATA_W(16), .MAX_LEN(8), .LEN_W(4), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .inj_en    (inj_en),
        .bus       (bus),
        .err_len   (err_len),
        .pkt_cnt   (pkt_cnt),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic p, input logic [3:0] l, input logic [15:0] s);
        bus.req_valid = v;
        bus.req_port  = p;
        bus.req_len   = l;
        bus.req_seed  = s;
    endtask

    // Settle, then check flit outputs and the valid/full exclusion.
    task automatic flit(input string tag, input logic v, input logic p, input logic h,
                        input logic t, input logic [15:0] d);
        #1;
        chk({tag, "_valid"}, bus.flit_valid, v);
        chk({tag, "_port"},  bus.flit_port, p);
        chk({tag, "_head"},  bus.flit_head, h);
        chk({tag, "_tail"},  bus.flit_tail, t);
        chk({tag, "_data"},  bus.flit_data, d);
        chk({tag, "_excl"},  bus.flit_valid && bus.fifo_full, 1'b0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_b   = 1'b0;
        inj_en  = 1'b1;
        bus.fifo_full = 1'b0;
        drive(1'b0, 1'b0, 4'd0, 16'h0);
        tick();
        tick();

        // Reset state
        flit("rst", 0, 0, 0, 0, 16'h0);
        chk("rst_ready", bus.req_ready, 1'b1);
        chk("rst_err", err_len, 1'b0);
        chk("rst_pkt", pkt_cnt, 16'd0);
        chk("rst_stall", stall_cnt, 16'd0);
        rst_b = 1'b1;
        tick();

        // len=3 port=1 seed=0x00FE
        drive(1'b1, 1'b1, 4'd3, 16'h00FE);
        #1 chk("p1_ready_idle", bus.req_ready, 1'b1);
        tick();
        drive(1'b0, 1'b0, 4'd0, 16'h0);
        flit("p1_f0", 1, 1, 1, 0, 16'h00FE);
        chk("p1_ready_body", bus.req_ready, 1'b0);
        tick();
        flit("p1_f1", 1, 1, 0, 0, 16'h00FF);
        tick();
        flit("p1_f2", 1, 1, 0, 1, 16'h0100);
        tick();
        flit("p1_idle", 0, 0, 0, 0, 16'h0);
        chk("p1_ready_after", bus.req_ready, 1'b1);
        chk("p1_pkt", pkt_cnt, 16'd1);

        // len=1 seed=0xFFFF, then back-to-back len=2
        drive(1'b1, 1'b0, 4'd1, 16'hFFFF);
        tick();
        drive(1'b1, 1'b1, 4'd2, 16'h1234);
        flit("p2_single", 1, 0, 1, 1, 16'hFFFF);
        chk("p2_ready_tail", bus.req_ready, 1'b1);
        tick();
        drive(1'b0, 1'b0, 4'd0, 16'h0);
        flit("p3_f0", 1, 1, 1, 0, 16'h1234);
        chk("p2_pkt", pkt_cnt, 16'd2);
        tick();
        flit("p3_f1", 1, 1, 0, 1, 16'h1235);
        tick();
        flit("p3_idle", 0, 0, 0, 0, 16'h0);
        chk("p3_pkt", pkt_cnt, 16'd3);

        // len=4 with fifo_full in SEND cycles 2-4
        drive(1'b1, 1'b0, 4'd4, 16'h0010);
        tick();
        drive(1'b0, 1'b0, 4'd0, 16'h0);
        flit("p4_f0", 1, 0, 1, 0, 16'h0010);
        tick();
        bus.fifo_full = 1'b1;
        flit("p4_stall1", 0, 0, 0, 0, 16'h0011);
        chk("p4_ready_stall", bus.req_ready, 1'b0);
        tick();
        flit("p4_stall2", 0, 0, 0, 0, 16'h0011);
        tick();
        flit("p4_stall3", 0, 0, 0, 0, 16'h0011);
        tick();
        bus.fifo_full = 1'b0;
        flit("p4_f1", 1, 0, 0, 0, 16'h0011);
        chk("p4_stall_cnt", stall_cnt, 16'd3);
        tick();
        flit("p4_f2", 1, 0, 0, 0, 16'h0012);
        tick();
        flit("p4_f3", 1, 0, 0, 1, 16'h0013);
        tick();
        flit("p4_idle", 0, 0, 0, 0, 16'h0);
        chk("p4_pkt", pkt_cnt, 16'd4);
        chk("p4_stall_hold", stall_cnt, 16'd3);

        // Illegal lengths 0 and 9
        drive(1'b1, 1'b1, 4'd0, 16'hAAAA);
        #1 chk("e0_ready", bus.req_ready, 1'b1);
        tick();
        drive(1'b0, 1'b0, 4'd0, 16'h0);
        flit("e0_noflit", 0, 0, 0, 0, 16'h0);
        chk("e0_err", err_len, 1'b1);
        tick();
        chk("e0_err_clr", err_len, 1'b0);
        drive(1'b1, 1'b0, 4'd9, 16'hBBBB);
        tick();
        drive(1'b0, 1'b0, 4'd0, 16'h0);
        flit("e9_noflit", 0, 0, 0, 0, 16'h0);
        chk("e9_err", err_len, 1'b1);
        tick();
        chk("e9_err_clr", err_len, 1'b0);
        chk("e_pkt", pkt_cnt, 16'd4);

        // len=5 with inj_en dropped after the head
        drive(1'b1, 1'b1, 4'd5, 16'h0200);
        tick();
        drive(1'b0, 1'b0, 4'd0, 16'h0);
        inj_en = 1'b0;
        flit("p5_f0", 1, 1, 1, 0, 16'h0200);
        tick();
        flit("p5_f1", 1, 1, 0, 0, 16'h0201);
        tick();
        flit("p5_f2", 1, 1, 0, 0, 16'h0202);
        tick();
        flit("p5_f3", 1, 1, 0, 0, 16'h0203);
        tick();
        drive(1'b1, 1'b0, 4'd2, 16'h0300);
        flit("p5_f4", 1, 1, 0, 1, 16'h0204);
        chk("p5_ready_blocked", bus.req_ready, 1'b0);
        tick();
        flit("p5_idle", 0, 0, 0, 0, 16'h0);
        chk("p5_ready_idle", bus.req_ready, 1'b0);
        chk("p5_pkt", pkt_cnt, 16'd5);
        tick();
        flit("p5_idle2", 0, 0, 0, 0, 16'h0);
        inj_en = 1'b1;
        #1 chk("p6_ready_en", bus.req_ready, 1'b1);
        tick();
        drive(1'b0, 1'b0, 4'd0, 16'h0);
        flit("p6_f0", 1, 0, 1, 0, 16'h0300);
        tick();
        flit("p6_f1", 1, 0, 0, 1, 16'h0301);
        tick();
        chk("p6_pkt", pkt_cnt, 16'd6);

        // len=6 interrupted by reset after its second flit
        drive(1'b1, 1'b0, 4'd6, 16'h0500);
        tick();
        drive(1'b0, 1'b0, 4'd0, 16'h0);
        flit("p7_f0", 1, 0, 1, 0, 16'h0500);
        tick();
        flit("p7_f1", 1, 0, 0, 0, 16'h0501);
        tick();
        rst_b = 1'b0;
        flit("p7_rst", 0, 0, 0, 0, 16'h0);
        chk("p7_rst_pkt", pkt_cnt, 16'd0);
        chk("p7_rst_stall", stall_cnt, 16'd0);
        tick();
        rst_b = 1'b1;
        drive(1'b1, 1'b1, 4'd2, 16'h0700);
        #1 chk("p8_ready", bus.req_ready, 1'b1);
        tick();
        drive(1'b0, 1'b0, 4'd0, 16'h0);
        flit("p8_f0", 1, 1, 1, 0, 16'h0700);
        tick();
        flit("p8_f1", 1, 1, 0, 1, 16'h0701);
        tick();
        flit("p8_idle", 0, 0, 0, 0, 16'h0);
        chk("p8_pkt", pkt_cnt, 16'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
